// File: rtl/combination_lock_pkg.sv
// Shared definitions for the combination lock: state encodings and the
// helper that extracts one digit from a packed code word.
package combination_lock_pkg;

  typedef enum logic [1:0] {
    S_ENTRY    = 2'b00,
    S_UNLOCKED = 2'b01,
    S_PROGRAM  = 2'b10,
    S_LOCKOUT  = 2'b11
  } state_t;

  localparam int unsigned CODE_MAX_W = 256;

  // Returns digit idx (dw bits wide, zero-extended) of a packed code word.
  function automatic logic [31:0] digit_slice(input logic [CODE_MAX_W-1:0] code,
                                              input int unsigned idx,
                                              input int unsigned dw);
    logic [CODE_MAX_W-1:0] sh;
    sh = code >> (idx * dw);
    return sh[31:0] & ~(32'hFFFF_FFFF << dw);
  endfunction

endpackage

// File: rtl/button_edge_detect.sv
// Rising-edge detector for a Clk-synchronous key level. History resets to 1
// so a key already held when reset releases does not count as a press.
module button_edge_detect (
  input  logic Clk,
  input  logic Reset_n,
  input  logic in,
  output logic pulse
);

  logic prev_q;
  logic prev_d;

  assign prev_d = in;
  assign pulse  = in & ~prev_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) prev_q <= 1'b1;
    else          prev_q <= prev_d;
  end

endmodule

// File: rtl/combination_lock_param.sv
// Sequential combination lock with programmable code, wrong-attempt lockout
// and auto-relock timeout. One digit is taken per Enter press.
module combination_lock_param
  import combination_lock_pkg::*;
#(
  parameter int SEQ_LEN        = 3,
  parameter int DIGIT_W        = 4,
  parameter logic [SEQ_LEN*DIGIT_W-1:0] DEFAULT_CODE = 12'h97D,
  parameter int MAX_FAILS      = 3,
  parameter int UNLOCK_CYCLES  = 20,
  parameter int LOCKOUT_CYCLES = 50,
  parameter int LOCK_W         = 4
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           Enter,
  input  logic [DIGIT_W-1:0]             Digit,
  input  logic                           Prog,
  input  logic                           Relock,
  output logic [1:0]                     state,
  output logic [LOCK_W-1:0]              Lock,
  output logic                           Lockout,
  output logic [$clog2(SEQ_LEN+1)-1:0]   DigitIdx,
  output logic [$clog2(MAX_FAILS+1)-1:0] FailCnt
);

  localparam int CW   = SEQ_LEN * DIGIT_W;
  localparam int IW   = $clog2(SEQ_LEN + 1);
  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(SEQ_LEN - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   code_q, code_d;
  logic [CW-1:0]   shadow_q, shadow_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            mis_q, mis_d;

  logic               press;
  logic [DIGIT_W-1:0] code_dig;
  logic               digit_ne;
  logic [TW-1:0]      tmr_inc;
  logic               unlock_to;

  button_edge_detect u_edge (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .in      (Enter),
    .pulse   (press)
  );

  assign code_dig  = DIGIT_W'(digit_slice(CODE_MAX_W'(code_q), 32'(idx_q), DIGIT_W));
  assign digit_ne  = (Digit != code_dig);
  assign tmr_inc   = (tmr_q == '1) ? tmr_q : tmr_q + TW'(1);
  assign unlock_to = (tmr_q == TW'(UNLOCK_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    fail_d   = fail_q;
    tmr_d    = tmr_q;
    mis_d    = mis_q;
    case (state_q)
      S_ENTRY: begin
        if (press) begin
          if (idx_q == LAST_IDX) begin
            // All digits are taken before judging, so timing leaks nothing.
            if (mis_q || digit_ne) begin
              fail_d = fail_q + FW'(1);
              if (fail_q == FW'(MAX_FAILS - 1)) state_d = S_LOCKOUT;
            end else begin
              fail_d  = '0;
              state_d = S_UNLOCKED;
            end
            idx_d = '0;
            mis_d = 1'b0;
            tmr_d = '0;
          end else begin
            idx_d = idx_q + IW'(1);
            mis_d = mis_q | digit_ne;
          end
        end
      end
      S_UNLOCKED: begin
        tmr_d = tmr_inc;
        if (Relock || unlock_to) state_d = S_ENTRY;
        else if (press && Prog)  state_d = S_PROGRAM;
      end
      S_PROGRAM: begin
        tmr_d = tmr_inc;
        if (Relock || unlock_to) begin
          state_d = S_ENTRY;
        end else if (press) begin
          for (int i = 0; i < SEQ_LEN; i++)
            if (idx_q == IW'(i)) shadow_d[i*DIGIT_W +: DIGIT_W] = Digit;
          if (idx_q == LAST_IDX) begin
            code_d  = shadow_d;
            state_d = S_ENTRY;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        tmr_d = tmr_inc;
        if (tmr_q == TW'(LOCKOUT_CYCLES - 1)) begin
          state_d = S_ENTRY;
          fail_d  = '0;
        end
      end
    endcase
    if (state_d != state_q) begin
      idx_d = '0;
      mis_d = 1'b0;
      tmr_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_ENTRY;
      code_q   <= DEFAULT_CODE;
      shadow_q <= DEFAULT_CODE;
      idx_q    <= '0;
      fail_q   <= '0;
      tmr_q    <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      fail_q   <= fail_d;
      tmr_q    <= tmr_d;
      mis_q    <= mis_d;
    end
  end

  assign state    = state_q;
  assign Lock     = (state_q == S_UNLOCKED) ? '1 : '0;
  assign Lockout  = (state_q == S_LOCKOUT);
  assign DigitIdx = idx_q;
  assign FailCnt  = fail_q;

endmodule

// File: tb/tb_combination_lock_param.sv
// Self-checking bench for combination_lock_param: table of press records plus
// hand sequences for timeouts, programming, lockout and reset corners.
module tb_combination_lock_param;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic       Enter;
  logic [3:0] Digit;
  logic       Prog;
  logic       Relock;
  logic [1:0] state;
  logic [3:0] Lock;
  logic       Lockout;
  logic [1:0] DigitIdx;
  logic [1:0] FailCnt;

  always #5 clk = ~clk;

  combination_lock_param dut (
    .Clk      (clk),
    .Reset_n  (Reset_n),
    .Enter    (Enter),
    .Digit    (Digit),
    .Prog     (Prog),
    .Relock   (Relock),
    .state    (state),
    .Lock     (Lock),
    .Lockout  (Lockout),
    .DigitIdx (DigitIdx),
    .FailCnt  (FailCnt)
  );

  typedef struct {
    logic [1:0] st;
    logic [1:0] idx;
    logic [1:0] fc;
    string      name;
  } exp_t;

  // enter=1: press (press cycle + release cycle); enter=0: one idle cycle.
  typedef struct {
    logic       enter;
    logic [3:0] digit;
    logic       prog;
    logic       relock;
    logic [1:0] st;
    logic [1:0] idx;
    logic [1:0] fc;
    string      name;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    chk({e.name, "/state"},    int'(state),    int'(e.st));
    chk({e.name, "/DigitIdx"}, int'(DigitIdx), int'(e.idx));
    chk({e.name, "/FailCnt"},  int'(FailCnt),  int'(e.fc));
    chk({e.name, "/Lock"},     int'(Lock),     (e.st == 2'b01) ? 15 : 0);
    chk({e.name, "/Lockout"},  int'(Lockout),  (e.st == 2'b11) ? 1 : 0);
  endtask

  task automatic check_now(input logic [1:0] st, input logic [1:0] idx,
                           input logic [1:0] fc, input string nm);
    sb.push_back('{st, idx, fc, nm});
    check_pop();
  endtask

  task automatic cyc(input logic e, input logic [3:0] d, input logic p, input logic r,
                     input logic [1:0] st, input logic [1:0] idx, input logic [1:0] fc,
                     input string nm);
    @(negedge clk);
    Enter  = e;
    Digit  = d;
    Prog   = p;
    Relock = r;
    sb.push_back('{st, idx, fc, nm});
    @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic press(input logic [3:0] d, input logic p, input logic [1:0] st,
                       input logic [1:0] idx, input logic [1:0] fc, input string nm);
    cyc(1'b1, d, p, 1'b0, st, idx, fc, {nm, "/press"});
    cyc(1'b0, d, 1'b0, 1'b0, st, idx, fc, {nm, "/release"});
  endtask

  task automatic add(input logic e, input logic [3:0] d, input logic p, input logic r,
                     input logic [1:0] st, input logic [1:0] idx, input logic [1:0] fc,
                     input string nm);
    tbl.push_back('{e, d, p, r, st, idx, fc, nm});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n = 1'b0;
    Enter   = 1'b0;
    Digit   = 4'd0;
    Prog    = 1'b0;
    Relock  = 1'b0;

    // Default code is 13,7,9 (digit 0 in the low nibble of 12'h97D).
    add(1, 13, 0, 0, 2'b00, 2'd1, 2'd0, "ok_d0");
    add(1,  7, 0, 0, 2'b00, 2'd2, 2'd0, "ok_d1");
    add(1,  9, 0, 0, 2'b01, 2'd0, 2'd0, "ok_unlock");
    add(1,  5, 0, 0, 2'b01, 2'd0, 2'd0, "noprog_ignored");
    add(0,  0, 0, 1, 2'b00, 2'd0, 2'd0, "relock");
    add(0,  0, 0, 0, 2'b00, 2'd0, 2'd0, "relock_idle");
    for (int k = 0; k < 3; k++) begin
      add(1, 13, 0, 0, 2'b00, 2'd1, 2'(k), "bad_d0");
      add(1,  6, 0, 0, 2'b00, 2'd2, 2'(k), "bad_d1");
      add(1,  9, 0, 0, (k == 2) ? 2'b11 : 2'b00, 2'd0, 2'(k + 1), "bad_d2");
    end

    repeat (2) @(posedge clk);
    #1;
    check_now(2'b00, 2'd0, 2'd0, "reset");
    @(negedge clk);
    Reset_n = 1'b1;

    foreach (tbl[i]) begin
      if (tbl[i].enter)
        press(tbl[i].digit, tbl[i].prog, tbl[i].st, tbl[i].idx, tbl[i].fc, tbl[i].name);
      else
        cyc(1'b0, tbl[i].digit, tbl[i].prog, tbl[i].relock,
            tbl[i].st, tbl[i].idx, tbl[i].fc, tbl[i].name);
    end

    // Lockout entered on the last bad press edge; the release was cycle 1.
    for (int i = 2; i < 50; i++)
      cyc(((i % 2) == 0), 4'd13, 1'b0, 1'b0, 2'b11, 2'd0, 2'd3, "lockout_hold");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 2'd0, 2'd0, "lockout_exit");

    press(0, 0, 2'b00, 2'd1, 2'd0, "bad_first_d0");
    press(7, 0, 2'b00, 2'd2, 2'd0, "bad_first_d1");
    press(9, 0, 2'b00, 2'd0, 2'd1, "bad_first_d2");
    press(13, 0, 2'b00, 2'd1, 2'd1, "clr_d0");
    press(7, 0, 2'b00, 2'd2, 2'd1, "clr_d1");
    press(9, 0, 2'b01, 2'd0, 2'd0, "clr_unlock");

    // Auto-relock: UNLOCKED lasts exactly 20 cycles.
    for (int i = 2; i < 20; i++)
      cyc(1'b0, 4'd0, 1'b0, 1'b0, 2'b01, 2'd0, 2'd0, "unlock_hold");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 2'd0, 2'd0, "unlock_timeout");

    press(13, 0, 2'b00, 2'd1, 2'd0, "pg_d0");
    press(7, 0, 2'b00, 2'd2, 2'd0, "pg_d1");
    press(9, 0, 2'b01, 2'd0, 2'd0, "pg_unlock");
    press(4, 1, 2'b10, 2'd0, 2'd0, "pg_enter");
    press(1, 0, 2'b10, 2'd1, 2'd0, "pg_w0");
    press(2, 0, 2'b10, 2'd2, 2'd0, "pg_w1");
    press(3, 0, 2'b00, 2'd0, 2'd0, "pg_commit");
    press(13, 0, 2'b00, 2'd1, 2'd0, "old_d0");
    press(7, 0, 2'b00, 2'd2, 2'd0, "old_d1");
    press(9, 0, 2'b00, 2'd0, 2'd1, "old_rejected");
    press(1, 0, 2'b00, 2'd1, 2'd1, "new_d0");
    press(2, 0, 2'b00, 2'd2, 2'd1, "new_d1");
    press(3, 0, 2'b01, 2'd0, 2'd0, "new_unlock");
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 2'b00, 2'd0, 2'd0, "new_relock");

    // Asynchronous reset mid-entry, away from any clock edge.
    press(1, 0, 2'b00, 2'd1, 2'd0, "mid_d0");
    @(negedge clk);
    Relock = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    check_now(2'b00, 2'd0, 2'd0, "async_reset");

    // Key held across reset release must not count as a press.
    Enter = 1'b1;
    Digit = 4'd13;
    @(negedge clk);
    Reset_n = 1'b1;
    cyc(1'b1, 4'd13, 1'b0, 1'b0, 2'b00, 2'd0, 2'd0, "held_c0");
    cyc(1'b1, 4'd13, 1'b0, 1'b0, 2'b00, 2'd0, 2'd0, "held_c1");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 2'd0, 2'd0, "held_release");

    // Reset restored the default code; then abort programming via Relock.
    press(13, 0, 2'b00, 2'd1, 2'd0, "rst_d0");
    press(7, 0, 2'b00, 2'd2, 2'd0, "rst_d1");
    press(9, 0, 2'b01, 2'd0, 2'd0, "rst_unlock");
    press(0, 1, 2'b10, 2'd0, 2'd0, "ab_enter");
    press(4, 0, 2'b10, 2'd1, 2'd0, "ab_w0");
    press(5, 0, 2'b10, 2'd2, 2'd0, "ab_w1");
    cyc(1'b1, 4'd6, 1'b0, 1'b1, 2'b00, 2'd0, 2'd0, "ab_relock_wins");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 2'd0, 2'd0, "ab_idle");
    press(4, 0, 2'b00, 2'd1, 2'd0, "ab_new_d0");
    press(5, 0, 2'b00, 2'd2, 2'd0, "ab_new_d1");
    press(6, 0, 2'b00, 2'd0, 2'd1, "ab_new_rejected");
    press(13, 0, 2'b00, 2'd1, 2'd1, "ab_old_d0");
    press(7, 0, 2'b00, 2'd2, 2'd1, "ab_old_d1");
    press(9, 0, 2'b01, 2'd0, 2'd0, "ab_old_unlock");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
